// File: rtl/puf_readout_controller.sv
// Sequences one PUF run per host request, turns loop-count pairs into response
// bits, packs them LSB-first into words and streams them through a small FIFO.
module puf_readout_controller #(
  parameter int NUM_LOOPS      = 1280,
  parameter int TOT_CNT_BITS   = 32,
  parameter int CHALLENGE_BITS = 4,
  parameter int WORD_BITS      = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CHALLENGE_BITS-1:0]     req_challenge,
  output logic                          puf_start,
  output logic [CHALLENGE_BITS-1:0]     puf_challenge,
  input  logic [TOT_CNT_BITS-1:0]       puf_loop_response,
  input  logic [$clog2(NUM_LOOPS-1):0]  puf_loop_number,
  input  logic                          puf_store_response,
  input  logic                          puf_done,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [WORD_BITS-1:0]          resp_data,
  output logic                          resp_last,
  output logic                          overflow,
  output logic                          busy
);

  localparam int POS_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int PAIR_W = $clog2(NUM_LOOPS/2 + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(WORD_BITS - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_LOOPS/2 - 1);
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CHALLENGE_BITS-1:0] r_challenge;
  logic                      r_start;
  logic [TOT_CNT_BITS-1:0]   r_holder;
  logic                      r_pairOk;
  logic [PAIR_W-1:0]         r_pairCnt;
  logic [POS_W-1:0]          r_wordPos;
  logic [WORD_BITS-1:0]      r_word;
  logic                      r_overflow;

  logic [WORD_BITS-1:0] r_memData [FIFO_DEPTH];
  logic                 r_memLast [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [PTR_W:0]       r_count;

  logic                 w_handshake;
  logic                 w_isOdd;
  logic                 w_pairBit;
  logic                 w_bitValid;
  logic [WORD_BITS-1:0] w_newWord;
  logic                 w_wordFull;
  logic                 w_flushPush;
  logic                 w_pushReq;
  logic [WORD_BITS-1:0] w_pushData;
  logic                 w_pushLast;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_unusedLoop;

  // Only the parity of the loop index matters for pairing.
  assign w_unusedLoop = ^puf_loop_number;

  assign w_handshake = (r_state == S_IDLE) && req_valid;
  assign w_isOdd     = puf_loop_number[0];
  assign w_pairBit   = (r_holder > puf_loop_response);
  assign w_bitValid  = (r_state == S_RUN) && puf_store_response && w_isOdd && r_pairOk;
  assign w_newWord   = r_word | (WORD_BITS'(w_pairBit) << r_wordPos);
  assign w_wordFull  = w_bitValid && (r_wordPos == LAST_POS);
  assign w_flushPush = (r_state == S_FLUSH) && (r_wordPos != '0);
  assign w_pushReq   = w_wordFull || w_flushPush;
  assign w_pushData  = w_flushPush ? r_word : w_newWord;
  assign w_pushLast  = w_flushPush ? 1'b1 : (r_pairCnt == LAST_PAIR);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_pop   = !w_empty && resp_ready;
  assign w_push  = w_pushReq && (!w_full || w_pop);
  assign w_drop  = w_pushReq && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_nextState = S_START;
      S_START: w_nextState = S_RUN;
      S_RUN:   if (puf_done) w_nextState = S_FLUSH;
      S_FLUSH: w_nextState = S_DRAIN;
      S_DRAIN: if (w_empty) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_challenge <= '0;
      r_start     <= 1'b0;
      r_holder    <= '0;
      r_pairOk    <= 1'b0;
      r_pairCnt   <= '0;
      r_wordPos   <= '0;
      r_word      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_start <= w_handshake;
      if (w_handshake) begin
        r_challenge <= req_challenge;
        r_overflow  <= 1'b0;
        r_pairOk    <= 1'b0;
        r_pairCnt   <= '0;
        r_wordPos   <= '0;
        r_word      <= '0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if ((r_state == S_RUN) && puf_store_response) begin
          if (!w_isOdd) begin
            r_holder <= puf_loop_response;
            r_pairOk <= 1'b1;
          end else if (r_pairOk) begin
            r_pairOk  <= 1'b0;
            r_pairCnt <= r_pairCnt + 1'b1;
            if (w_wordFull) begin
              r_word    <= '0;
              r_wordPos <= '0;
            end else begin
              r_word    <= w_newWord;
              r_wordPos <= r_wordPos + 1'b1;
            end
          end
        end
        if (w_flushPush) begin
          r_word    <= '0;
          r_wordPos <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memData[r_wrPtr] <= w_pushData;
      r_memLast[r_wrPtr] <= w_pushLast;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign puf_start     = r_start;
  assign puf_challenge = r_challenge;
  assign overflow      = r_overflow;
  assign resp_valid    = !w_empty;
  assign resp_data     = w_empty ? '0 : r_memData[r_rdPtr];
  assign resp_last     = w_empty ? 1'b0 : r_memLast[r_rdPtr];

endmodule
